// File: rtl/fifo_feeder.sv
// fifo_feeder - load/drain controller for a bank of LANES shift-register
// delay buffers, each DEPTH entries deep, feeding a systolic MAC array.
//
// LOAD accepts LANES*DEPTH words over a valid/ready stream. Word k goes to
// lane k/DEPTH. DRAIN shifts zeros into every lane so the buffers present
// their contents to the array.
//
// Build option:
//   FEEDER_SKEW_EN  defined   : staggered drain, lane L enabled for
//                               drain_cnt in [L, L+DEPTH), DEPTH+LANES-1 cycles
//                   undefined : all lanes drain together for DEPTH cycles
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          begin a load (honoured only in IDLE)
//   in_valid       input word valid
//   in_data        input word
//   in_ready       word accepted this cycle when in_valid (LOAD only)
//   fifo_en        per-lane shift enable to the delay buffers
//   fifo_d         per-lane shift-in data, lane L at [L*BITS +: BITS]
//   lane_valid     lane L buffer output holds a valid operand
//   busy           controller not idle
//   done           one-cycle pulse when the drain completes
//
// state  | meaning
// -------+-----------------------------------------------------
// IDLE   | waiting for start, no stream handshake
// LOAD   | accepting words, steering each to its lane
// DRAIN  | shifting zeros in, lane_valid marks live operands
// DONE   | one-cycle completion pulse, then back to IDLE
module fifo_feeder #(
  parameter int LANES = 8,
  parameter int DEPTH = 8,
  parameter int BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [BITS-1:0]       in_data,
  output logic                  in_ready,
  output logic [LANES-1:0]      fifo_en,
  output logic [LANES*BITS-1:0] fifo_d,
  output logic [LANES-1:0]      lane_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int TOTAL = LANES * DEPTH;
  localparam int WW    = $clog2(TOTAL) + 1;
  localparam int LW    = $clog2(LANES);
  localparam int PW    = $clog2(DEPTH);
`ifdef FEEDER_SKEW_EN
  localparam int DRAIN_LEN = DEPTH + LANES - 1;
`else
  localparam int DRAIN_LEN = DEPTH;
`endif
  localparam int DW = $clog2(DRAIN_LEN) + 1;

  localparam logic [WW-1:0] LAST_WORD  = WW'(TOTAL - 1);
  localparam logic [PW-1:0] LAST_POS   = PW'(DEPTH - 1);
  localparam logic [DW-1:0] LAST_DRAIN = DW'(DRAIN_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] word_cnt;
  logic [LW-1:0] lane_cnt;   // lane of the next word (word_cnt / DEPTH)
  logic [PW-1:0] pos_cnt;    // position within that lane (word_cnt % DEPTH)
  logic [DW-1:0] drain_cnt;

  logic accept;
  logic last_word;
  logic last_drain;

  assign accept     = (state_q == S_LOAD) && in_valid;
  assign last_word  = accept && (word_cnt == LAST_WORD);
  assign last_drain = (state_q == S_DRAIN) && (drain_cnt == LAST_DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  if (last_word) state_d = S_DRAIN;
      S_DRAIN: if (last_drain) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lane and position are tracked separately so the steering decode needs
  // no divider when DEPTH is not a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt  <= '0;
      lane_cnt  <= '0;
      pos_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        word_cnt  <= '0;
        lane_cnt  <= '0;
        pos_cnt   <= '0;
        drain_cnt <= '0;
      end else if (accept) begin
        word_cnt <= word_cnt + WW'(1);
        if (pos_cnt == LAST_POS) begin
          pos_cnt  <= '0;
          lane_cnt <= lane_cnt + LW'(1);
        end else begin
          pos_cnt <= pos_cnt + PW'(1);
        end
      end else if (state_q == S_DRAIN && !last_drain) begin
        drain_cnt <= drain_cnt + DW'(1);
      end
    end
  end

`ifdef FEEDER_SKEW_EN
  int drain_idx;
  assign drain_idx = int'(drain_cnt);
`endif

  always_comb begin
    in_ready   = 1'b0;
    fifo_en    = '0;
    fifo_d     = '0;
    lane_valid = '0;
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    case (state_q)
      S_LOAD: begin
        in_ready = 1'b1;
        // The accepted word is steered to its lane in the same cycle.
        if (in_valid) begin
          for (int l = 0; l < LANES; l++) begin
            if (lane_cnt == LW'(l)) begin
              fifo_en[l]             = 1'b1;
              fifo_d[l*BITS +: BITS] = in_data;
            end
          end
        end
      end
      S_DRAIN: begin
`ifdef FEEDER_SKEW_EN
        for (int l = 0; l < LANES; l++) begin
          fifo_en[l] = (drain_idx >= l) && (drain_idx < l + DEPTH);
        end
`else
        fifo_en = '1;
`endif
        lane_valid = fifo_en;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fifo_feeder.sv
module tb_fifo_feeder;

  localparam int LANES = 8;
  localparam int DEPTH = 8;
  localparam int BITS  = 8;
  localparam int TOTAL = LANES * DEPTH;
`ifdef FEEDER_SKEW_EN
  localparam bit SKEW      = 1'b1;
  localparam int DRAIN_LEN = DEPTH + LANES - 1;
`else
  localparam bit SKEW      = 1'b0;
  localparam int DRAIN_LEN = DEPTH;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic                  in_valid;
  logic [BITS-1:0]       in_data;
  logic                  in_ready;
  logic [LANES-1:0]      fifo_en;
  logic [LANES*BITS-1:0] fifo_d;
  logic [LANES-1:0]      lane_valid;
  logic                  busy;
  logic                  done;

  int errors = 0;
  int checks = 0;

  // Downstream delay-buffer model: bufm[l][0] newest, bufm[l][DEPTH-1] oldest.
  logic [BITS-1:0] bufm [LANES][DEPTH];
  // Scoreboard: words expected out of each lane, in load order.
  logic [BITS-1:0] exp_q [LANES][$];

  fifo_feeder #(.LANES(LANES), .DEPTH(DEPTH), .BITS(BITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .fifo_en(fifo_en),
    .fifo_d(fifo_d), .lane_valid(lane_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LANES-1:0] drain_mask(input int c);
    logic [LANES-1:0] m;
    m = '0;
    for (int l = 0; l < LANES; l++)
      m[l] = SKEW ? (c >= l && c < l + DEPTH) : (c < DEPTH);
    return m;
  endfunction

  task automatic clear_model();
    for (int l = 0; l < LANES; l++) begin
      exp_q[l].delete();
      for (int i = 0; i < DEPTH; i++) bufm[l][i] = '0;
    end
  endtask

  // Apply the sampled enables/data to the buffer model (what the clock edge does).
  task automatic shift_model();
    for (int l = 0; l < LANES; l++) begin
      if (fifo_en[l]) begin
        for (int i = DEPTH - 1; i > 0; i--) bufm[l][i] = bufm[l][i-1];
        bufm[l][0] = fifo_d[l*BITS +: BITS];
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, in_ready, 1'b0);
    chk({tag, "_en"}, fifo_en, '0);
    chk({tag, "_d"}, fifo_d, '0);
    chk({tag, "_lv"}, lane_valid, '0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  // gap_mode: 0 no gaps, 1 valid only on odd load cycles, 2 random gaps.
  // data_mode: 0 word k carries value k, 1 random data.
  // abort_at > 0: reset after that many accepted words, then return.
  task automatic run_txn(input int gap_mode, input int data_mode,
                         input bit mid_start, input int abort_at);
    int k;
    int cyc;
    int lane;
    logic v;
    logic [BITS-1:0] w;
    logic [LANES-1:0] m;
    logic [BITS-1:0] ew;

    // IDLE cycle with start
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hA5;
    @(negedge clk);
    chk("idle_ready", in_ready, 1'b0);
    chk("idle_en", fifo_en, '0);
    chk("idle_busy", busy, 1'b0);
    next_cycle();
    start = 1'b0;

    k = 0;
    cyc = 0;
    while (k < TOTAL && cyc < 400) begin
      if (abort_at > 0 && k == abort_at) begin
        rst_n = 1'b0;
        in_valid = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check_idle_outputs("abort");
        next_cycle();
        @(negedge clk);
        chk("abort_hold_ready", in_ready, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        clear_model();
        @(negedge clk);
        check_idle_outputs("post_abort");
        next_cycle();
        return;
      end
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = cyc[0];
        default: v = 1'($urandom_range(0, 1));
      endcase
      w = (data_mode == 0) ? BITS'(k) : BITS'($urandom);
      in_valid = v;
      in_data  = w;
      start    = 1'($urandom_range(0, 1));
      lane = k / DEPTH;
      @(negedge clk);
      chk("load_ready", in_ready, 1'b1);
      chk("load_busy", busy, 1'b1);
      chk("load_lv", lane_valid, '0);
      if (v) begin
        chk("load_en", fifo_en, LANES'(1) << lane);
        chk("load_d", fifo_d[lane*BITS +: BITS], w);
        exp_q[lane].push_back(w);
        k++;
      end else begin
        chk("load_en_idle", fifo_en, '0);
      end
      shift_model();
      next_cycle();
      cyc++;
    end
    chk("load_words", k, TOTAL);
    if (gap_mode == 0) chk("load_cycles", cyc, TOTAL);
    if (gap_mode == 1) chk("load_cycles", cyc, 2 * TOTAL);
    start = 1'b0;

    for (int c = 0; c < DRAIN_LEN; c++) begin
      start    = mid_start && (c == 3);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = BITS'($urandom);
      m = drain_mask(c);
      @(negedge clk);
      chk("drain_en", fifo_en, m);
      chk("drain_lv", lane_valid, m);
      chk("drain_d", fifo_d, '0);
      chk("drain_ready", in_ready, 1'b0);
      chk("drain_busy", busy, 1'b1);
      chk("drain_done", done, 1'b0);
      for (int l = 0; l < LANES; l++) begin
        if (m[l]) begin
          ew = (exp_q[l].size() > 0) ? exp_q[l].pop_front() : 'x;
          chk("lane_data", bufm[l][DEPTH-1], ew);
        end
      end
      shift_model();
      next_cycle();
    end
    start = 1'b0;
    in_valid = 1'b0;

    @(negedge clk);
    chk("done_pulse", done, 1'b1);
    chk("done_busy", busy, 1'b1);
    chk("done_en", fifo_en, '0);
    chk("done_ready", in_ready, 1'b0);
    for (int l = 0; l < LANES; l++) begin
      chk("leftover", exp_q[l].size(), 0);
      chk("zero_fill", bufm[l][DEPTH-1], '0);
    end
    next_cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h3C;
    clear_model();

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_outputs("reset");
      next_cycle();
    end
    rst_n = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_reset");
    next_cycle();

    // Full directed load 0x00..0x3F, no gaps
    run_txn(0, 0, 1'b0, 0);
    // Back-to-back: alternate gaps, random data, start pulsed mid-drain
    run_txn(1, 1, 1'b1, 0);
    @(negedge clk);
    check_idle_outputs("after_done");
    next_cycle();
    // Random gaps and data
    run_txn(2, 1, 1'b1, 0);
    // Abort after 20 words, then a clean transaction
    run_txn(0, 0, 1'b0, 20);
    run_txn(0, 1, 1'b0, 0);
    @(negedge clk);
    check_idle_outputs("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout simulation did not finish errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
